encrypt_pipe_shift_rot: RTL and testbench

ENCRYPT_PIPE_SHIFT_ROT -- requirements
Module: encrypt_pipe_shift_rot

---
 rtl/encrypt_pipe_pkg.sv | 35 +++
 rtl/encrypt_onehot_enc.sv | 25 ++
 rtl/encrypt_pipe_shift_rot.sv | 122 ++++++++++++
 tb/tb_encrypt_pipe_shift_rot.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/encrypt_pipe_pkg.sv
// Shared definitions for the shift/rotate encryption stage.
// Holds the alphabet size, ASCII bases, the one-hot letter and step types,
// and ring-rotation helpers used by encrypt_pipe_shift_rot.
// Optional feature macro: ENCRYPT_ROT_DECRYPT_EN (adds the right-rotate helper).
package encrypt_pipe_pkg;

  localparam int         ALPHA_LEN        = 26;
  localparam logic [7:0] ASCII_UPPER_BASE = 8'd65;
  localparam logic [7:0] ASCII_LOW_BASE   = 8'd97;

  typedef logic [ALPHA_LEN-1:0] onehot_t;
  typedef logic [4:0]           step_t;

  // Left rotate within the 26-bit ring. Doubling the word turns the wrap into
  // a plain part-select; n must already be reduced to 0..25.
  function automatic onehot_t rotl(input onehot_t x, input step_t n);
    logic [2*ALPHA_LEN-1:0] d;
    logic [5:0]             base;
    d    = {x, x};
    base = 6'(ALPHA_LEN) - {1'b0, n};
    return d[base +: ALPHA_LEN];
  endfunction

`ifdef ENCRYPT_ROT_DECRYPT_EN
  // Right rotate within the 26-bit ring; n must be 0..25.
  function automatic onehot_t rotr(input onehot_t x, input step_t n);
    logic [2*ALPHA_LEN-1:0] d;
    logic [5:0]             base;
    d    = {x, x};
    base = {1'b0, n};
    return d[base +: ALPHA_LEN];
  endfunction
`endif

endpackage

// File: rtl/encrypt_onehot_enc.sv
// One-hot to index encoder for the 26-letter alphabet.
// Ports:
//   i_onehot : 26-bit letter vector
//   o_idx    : index of the set bit (meaningful only when o_valid)
//   o_valid  : exactly one bit of i_onehot is set
module encrypt_onehot_enc
  import encrypt_pipe_pkg::*;
(
  input  onehot_t    i_onehot,
  output logic [4:0] o_idx,
  output logic       o_valid
);

  // OR of the indices of all set bits; only trusted when exactly one is set.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < ALPHA_LEN; i++) begin
      if (i_onehot[i]) o_idx = o_idx | 5'(i);
    end
  end

  // x & (x-1) clears the lowest set bit, so a zero result means at most one bit.
  assign o_valid = (i_onehot != '0) && ((i_onehot & (i_onehot - onehot_t'(1))) == '0);

endmodule

// File: rtl/encrypt_pipe_shift_rot.sv
// Shift/rotate stage of the character encryption pipe.
// Rotates a one-hot letter by (shift_amt + step) mod 26 and emits ASCII one
// cycle later. The step advances every rot_freq counted alpha characters.
// Optional feature macro: ENCRYPT_ROT_DECRYPT_EN adds input dir (1 = rotate right).
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   en_in           : character valid
//   is_upper_in/is_low_in : alpha class flags
//   ext_data_in     : one-hot letter in [25:0] or raw byte in [7:0]
//   shift_amt       : base shift 0..15
//   rot_freq        : alpha characters per step increment, 0 = hold
//   clr             : synchronous clear of the step schedule
//   dir             : (macro only) 0 = encrypt, 1 = decrypt
//   en_out, dout    : registered valid and ASCII result
//   step_out        : current schedule step 0..25
module encrypt_pipe_shift_rot
  import encrypt_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_in,
  input  logic        is_upper_in,
  input  logic        is_low_in,
  input  logic [31:0] ext_data_in,
  input  logic [3:0]  shift_amt,
  input  logic [2:0]  rot_freq,
  input  logic        clr,
`ifdef ENCRYPT_ROT_DECRYPT_EN
  input  logic        dir,
`endif
  output logic        en_out,
  output logic [7:0]  dout,
  output logic [4:0]  step_out
);

  logic [2:0] r_cnt;
  step_t      r_step;
  logic       r_en;
  logic [7:0] r_dout;

  logic       w_alpha;
  logic [5:0] w_sum;
  step_t      w_eff;
  onehot_t    w_rot;
  logic [4:0] w_idx;
  logic       w_valid;
  logic       w_count;
  logic [3:0] w_cnt_inc;
  logic       w_wrap;
  step_t      w_step_inc;
  logic [7:0] w_dout_next;

  assign w_alpha = en_in & (is_upper_in ^ is_low_in);

  // Max sum is 15 + 25 = 40, so one conditional subtract reduces mod 26.
  assign w_sum = {2'b00, shift_amt} + {1'b0, r_step};
  assign w_eff = (w_sum >= 6'(ALPHA_LEN)) ? 5'(w_sum - 6'(ALPHA_LEN)) : w_sum[4:0];

`ifdef ENCRYPT_ROT_DECRYPT_EN
  assign w_rot = dir ? rotr(ext_data_in[ALPHA_LEN-1:0], w_eff)
                     : rotl(ext_data_in[ALPHA_LEN-1:0], w_eff);
`else
  assign w_rot = rotl(ext_data_in[ALPHA_LEN-1:0], w_eff);
`endif

  encrypt_onehot_enc u_enc (
    .i_onehot (w_rot),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  // Rotation preserves popcount, so validity of the rotated word equals
  // validity of the input letter.
  assign w_count = w_alpha & w_valid;

  // ">=" rather than "==" so a rot_freq lowered below the live count wraps
  // immediately on the next counted character.
  assign w_cnt_inc  = {1'b0, r_cnt} + 4'd1;
  assign w_wrap     = w_cnt_inc >= {1'b0, rot_freq};
  assign w_step_inc = (r_step == 5'(ALPHA_LEN - 1)) ? '0 : r_step + 5'd1;

  always_comb begin
    w_dout_next = '0;
    if (en_in) begin
      if (!is_upper_in && !is_low_in) begin
        w_dout_next = ext_data_in[7:0];
      end else if (w_count) begin
        w_dout_next = (is_upper_in ? ASCII_UPPER_BASE : ASCII_LOW_BASE) + {3'b000, w_idx};
      end
    end
  end

  // Output register plus schedule; clr overrides any increment on the same edge,
  // while the character itself already used the pre-clear step above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en   <= 1'b0;
      r_dout <= '0;
      r_cnt  <= '0;
      r_step <= '0;
    end else begin
      r_en   <= en_in;
      r_dout <= w_dout_next;
      if (clr) begin
        r_cnt  <= '0;
        r_step <= '0;
      end else if (w_count && (rot_freq != 3'd0)) begin
        if (w_wrap) begin
          r_cnt  <= '0;
          r_step <= w_step_inc;
        end else begin
          r_cnt  <= w_cnt_inc[2:0];
        end
      end
    end
  end

  assign en_out   = r_en;
  assign dout     = r_dout;
  assign step_out = r_step;

endmodule

// File: tb/tb_encrypt_pipe_shift_rot.sv
// Self-checking bench for encrypt_pipe_shift_rot.
// A driver issues characters and pushes the reference result into a queue;
// a monitor pops and compares whenever en_out is high.
// Optional feature macro: ENCRYPT_ROT_DECRYPT_EN (exercises dir).
module tb_encrypt_pipe_shift_rot;

  logic        clk;
  logic        rst;
  logic        en_in;
  logic        is_upper_in;
  logic        is_low_in;
  logic [31:0] ext_data_in;
  logic [3:0]  shift_amt;
  logic [2:0]  rot_freq;
  logic        clr;
  logic        dir;
  logic        en_out;
  logic [7:0]  dout;
  logic [4:0]  step_out;

  typedef struct packed {
    logic [7:0] d;
    logic [4:0] s;
  } exp_t;

  exp_t q[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   mCnt    = 0;
  int   mStep   = 0;

  encrypt_pipe_shift_rot dut (
    .clk         (clk),
    .rst         (rst),
    .en_in       (en_in),
    .is_upper_in (is_upper_in),
    .is_low_in   (is_low_in),
    .ext_data_in (ext_data_in),
    .shift_amt   (shift_amt),
    .rot_freq    (rot_freq),
    .clr         (clr),
`ifdef ENCRYPT_ROT_DECRYPT_EN
    .dir         (dir),
`endif
    .en_out      (en_out),
    .dout        (dout),
    .step_out    (step_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: decode the letter position, shift it arithmetically around the
  // alphabet, and keep the schedule as two integers.
  task automatic applyStimulus(input logic en, input logic up, input logic lo,
                               input logic [31:0] ext, input logic [3:0] sh,
                               input logic [2:0] fr, input logic cl, input logic d);
    int   ones, idx, eff, n;
    logic legal;
    exp_t e;
    @(posedge clk);
    #1;
    en_in = en; is_upper_in = up; is_low_in = lo; ext_data_in = ext;
    shift_amt = sh; rot_freq = fr; clr = cl; dir = d;
    ones = 0; idx = 0;
    for (int k = 0; k < 26; k++) if (ext[k]) begin ones++; idx = k; end
    legal = en && (up != lo) && (ones == 1);
`ifndef ENCRYPT_ROT_DECRYPT_EN
    d = 1'b0;
`endif
    e.d = 8'd0;
    if (en && !up && !lo) e.d = ext[7:0];
    else if (legal) begin
      eff = (int'(sh) + mStep) % 26;
      n   = d ? (idx - eff + 26) % 26 : (idx + eff) % 26;
      e.d = 8'((up ? 65 : 97) + n);
    end
    if (cl) begin
      mCnt = 0; mStep = 0;
    end else if (legal && fr != 0) begin
      mCnt = mCnt + 1;
      if (mCnt >= int'(fr)) begin
        mCnt = 0;
        mStep = (mStep + 1) % 26;
      end
    end
    e.s = 5'(mStep);
    if (en) q.push_back(e);
  endtask

  task automatic alphaChar(input int k, input logic up, input logic [3:0] sh,
                           input logic [2:0] fr, input logic d);
    applyStimulus(1'b1, up, ~up, 32'd1 << k, sh, fr, 1'b0, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'd0, rot_freq, 1'b0, 1'b0);
  endtask

  // Mid-stream reset: outputs must clear before any clock edge.
  task automatic doReset();
    idle(2);
    @(posedge clk);
    #2;
    rst = 1'b0;
    en_in = 1'b0;
    #1;
    checkOutput("rst_en_out", en_out, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_step_out", step_out, 0);
    mCnt = 0; mStep = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      if (en_out) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_en_out", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          checkOutput("dout", dout, e.d);
          checkOutput("step_out", step_out, e.s);
        end
      end else begin
        checkOutput("idle_dout", dout, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; en_in = 0; is_upper_in = 0; is_low_in = 0; ext_data_in = 0;
    shift_amt = 0; rot_freq = 0; clr = 0; dir = 0;
    #3;
    checkOutput("reset_en_out", en_out, 0);
    checkOutput("reset_dout", dout, 0);
    checkOutput("reset_step_out", step_out, 0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;

    // 'A' + 3 -> 'D'; 'z' + 1 wraps to 'a'
    alphaChar(0, 1'b1, 4'd3, 3'd0, 1'b0);
    alphaChar(25, 1'b0, 4'd1, 3'd0, 1'b0);

    // Step schedule every two characters: a,a,b,b,c
    for (int i = 0; i < 5; i++) alphaChar(0, 1'b0, 4'd0, 3'd2, 1'b0);
    // Raw byte mid-stream, then a letter to show the schedule did not move
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0035, 4'd0, 3'd2, 1'b0, 1'b0);
    alphaChar(0, 1'b0, 4'd0, 3'd2, 1'b0);

    // Illegal: both flags, empty one-hot, multi-hot
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h1, 4'd2, 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 4'd2, 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h5, 4'd2, 3'd2, 1'b0, 1'b0);
    alphaChar(1, 1'b1, 4'd0, 3'd2, 1'b0);

    // clr with a simultaneous letter uses the pre-clear step
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h4, 4'd0, 3'd1, 1'b1, 1'b0);
    // Lower rot_freq below the live count
    for (int i = 0; i < 3; i++) alphaChar(i, 1'b1, 4'd0, 3'd4, 1'b0);
    alphaChar(7, 1'b1, 4'd0, 3'd2, 1'b0);

    // Reach step 5, reset, then 'A' with shift 0 gives 'A'
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) alphaChar(2, 1'b1, 4'd0, 3'd1, 1'b0);
    doReset();
    alphaChar(0, 1'b1, 4'd0, 3'd0, 1'b0);

`ifdef ENCRYPT_ROT_DECRYPT_EN
    alphaChar(3, 1'b1, 4'd3, 3'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) alphaChar(i, 1'b0, 4'd0, 3'd1, 1'b0);
    alphaChar(3, 1'b1, 4'd15, 3'd0, 1'b1);
`endif

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic       en, up, lo, cl, d;
      logic [31:0] ext;
      logic [2:0] fr;
      int         cls;
      en  = ($urandom_range(0, 99) < 85);
      cls = $urandom_range(0, 9);
      up  = (cls <= 3) || (cls == 9);
      lo  = (cls >= 4 && cls <= 7) || (cls == 9);
      ext = ($urandom_range(0, 9) == 0) ? $urandom() : (32'd1 << $urandom_range(0, 25));
      if (cls == 8) ext = $urandom();
      fr  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : rot_freq;
      cl  = ($urandom_range(0, 19) == 0);
      d   = 1'($urandom_range(0, 1));
      applyStimulus(en, up, lo, ext, 4'($urandom_range(0, 15)), fr, cl, d);
      if (i == 200) doReset();
    end

    idle(3);
    checkOutput("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
